wb_arbiter: RTL and testbench

Writeback arbiter for the Raisin64 back end. It collects results from two execution units, buffers each stream in a small per-unit FIFO, and drives the single register-file write port. On the same cycle as each write it presents the destination register on the pending-register-table free port, so the scoreboard releases the register exactly when the write lands.

---
 rtl/wb_arbiter_if.sv | 30 +++
 rtl/wb_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two execution units, the writeback arbiter and the
// register-file / scoreboard ports.
interface wb_arbiter_if #(
  parameter int DATA_W = 64
);
  logic              eu0_valid;
  logic [5:0]        eu0_rn;
  logic [DATA_W-1:0] eu0_data;
  logic              eu0_ready;
  logic              eu1_valid;
  logic [5:0]        eu1_rn;
  logic [DATA_W-1:0] eu1_data;
  logic              eu1_ready;
  logic              rf_we;
  logic [5:0]        rf_rn;
  logic [DATA_W-1:0] rf_data;
  logic [5:0]        free0_rn;
  logic [5:0]        free1_rn;
  logic              idle;

  // master: the result producers; slave: the arbiter
  modport master (
    output eu0_valid, eu0_rn, eu0_data, eu1_valid, eu1_rn, eu1_data,
    input  eu0_ready, eu1_ready, rf_we, rf_rn, rf_data, free0_rn, free1_rn, idle
  );
  modport slave (
    input  eu0_valid, eu0_rn, eu0_data, eu1_valid, eu1_rn, eu1_data,
    output eu0_ready, eu1_ready, rf_we, rf_rn, rf_data, free0_rn, free1_rn, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two per-unit result FIFOs feeding one register-file write
// port. Define WB_RR_EN for round-robin tie-break; otherwise unit 0 wins ties.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [5:0]        mem_rn   [2][DEPTH];
  logic [DATA_W-1:0] mem_data [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [2];
  logic [PTR_W-1:0]  rd_ptr   [2];
  logic [CNT_W-1:0]  count    [2];

  logic [1:0]        in_valid;
  logic [5:0]        in_rn    [2];
  logic [DATA_W-1:0] in_data  [2];
  logic [1:0]        ready;
  logic [1:0]        head_vld;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic              gnt_any;
  logic              gnt_sel;
  logic              tie_sel;
  logic [5:0]        head_rn;
  logic [DATA_W-1:0] head_data;

  logic              rf_we_q;
  logic [5:0]        rf_rn_q;
  logic [DATA_W-1:0] rf_data_q;

  assign in_valid   = {bus.eu1_valid, bus.eu0_valid};
  assign in_rn[0]   = bus.eu0_rn;
  assign in_rn[1]   = bus.eu1_rn;
  assign in_data[0] = bus.eu0_data;
  assign in_data[1] = bus.eu1_data;

  // Ready looks only at current occupancy, so a full FIFO stays closed for
  // the whole cycle even while it is being popped.
  always_comb begin
    ready    = '0;
    head_vld = '0;
    for (int u = 0; u < 2; u++) begin
      ready[u]    = (count[u] != CNT_W'(DEPTH));
      head_vld[u] = (count[u] != '0);
    end
    push = in_valid & ready;
  end

`ifdef WB_RR_EN
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last <= 1'b1;
    else if (gnt_any) last <= gnt_sel;
  end

  assign tie_sel = ~last;
`else
  assign tie_sel = 1'b0;
`endif

  always_comb begin
    gnt_any = |head_vld;
    gnt_sel = 1'b0;
    pop     = '0;
    if (head_vld == 2'b11) gnt_sel = tie_sel;
    else                   gnt_sel = ~head_vld[0];
    if (gnt_any) pop[gnt_sel] = 1'b1;
  end

  assign head_rn   = mem_rn[gnt_sel][rd_ptr[gnt_sel]];
  assign head_data = mem_data[gnt_sel][rd_ptr[gnt_sel]];

  always_ff @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (push[u]) begin
        mem_rn[u][wr_ptr[u]]   <= in_rn[u];
        mem_data[u][wr_ptr[u]] <= in_data[u];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        count[u]  <= '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (push[u]) wr_ptr[u] <= wr_ptr[u] + PTR_W'(1);
        if (pop[u])  rd_ptr[u] <= rd_ptr[u] + PTR_W'(1);
        count[u] <= count[u] + CNT_W'(push[u]) - CNT_W'(pop[u]);
      end
    end
  end

  // r0 entries are consumed but never written or released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_rn_q   <= '0;
      rf_data_q <= '0;
    end else if (gnt_any) begin
      rf_we_q   <= (head_rn != 6'd0);
      rf_rn_q   <= head_rn;
      rf_data_q <= head_data;
    end else begin
      rf_we_q   <= 1'b0;
    end
  end

  assign bus.eu0_ready = ready[0];
  assign bus.eu1_ready = ready[1];
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rn     = rf_rn_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.free0_rn  = rf_we_q ? rf_rn_q : 6'd0;
  assign bus.free1_rn  = 6'd0;
  assign bus.idle      = (count[0] == '0) && (count[1] == '0) && !rf_we_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; expected write order follows WB_RR_EN.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  wb_arbiter_if #(.DATA_W(64)) bus ();

  wb_arbiter #(.DEPTH(4), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.eu0_valid = 1'b0; bus.eu0_rn = '0; bus.eu0_data = '0;
    bus.eu1_valid = 1'b0; bus.eu1_rn = '0; bus.eu1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [4];
    int got_order [$];
    int acc, w, n, writes;
    bit dropped, found, prev_ready, take;

    // reset state
    idle_inputs();
    @(negedge clk);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_rn", bus.rf_rn, 0);
    check("rst_rf_data", bus.rf_data, 0);
    check("rst_free0", bus.free0_rn, 0);
    check("rst_free1", bus.free1_rn, 0);
    check("rst_idle", bus.idle, 1);
    check("rst_rdy0", bus.eu0_ready, 1);
    check("rst_rdy1", bus.eu1_ready, 1);

    // single push latency
    do_reset();
    bus.eu0_valid = 1'b1; bus.eu0_rn = 6'd5; bus.eu0_data = 64'h1234;
    @(negedge clk);
    check("lat_e1_we", bus.rf_we, 0);
    idle_inputs();
    @(negedge clk);
    check("lat_we", bus.rf_we, 1);
    check("lat_rn", bus.rf_rn, 5);
    check("lat_data", bus.rf_data, 64'h1234);
    check("lat_free0", bus.free0_rn, 5);
    check("lat_free1", bus.free1_rn, 0);
    @(negedge clk);
    check("lat_idle", bus.idle, 1);
    check("lat_we_off", bus.rf_we, 0);
    check("lat_free0_off", bus.free0_rn, 0);

    // tie-break order
`ifdef WB_RR_EN
    exp_order = '{3, 7, 4, 8};
`else
    exp_order = '{3, 4, 7, 8};
`endif
    do_reset();
    bus.eu0_valid = 1'b1; bus.eu0_rn = 6'd3; bus.eu0_data = 64'h33;
    bus.eu1_valid = 1'b1; bus.eu1_rn = 6'd7; bus.eu1_data = 64'h77;
    @(negedge clk);
    bus.eu0_rn = 6'd4; bus.eu0_data = 64'h44;
    bus.eu1_rn = 6'd8; bus.eu1_data = 64'h88;
    @(negedge clk);
    idle_inputs();
    got_order.delete();
    for (int c = 0; c < 10 && got_order.size() < 4; c++) begin
      if (bus.rf_we) got_order.push_back(int'(bus.rf_rn));
      @(negedge clk);
    end
    check("tie_count", got_order.size(), 4);
    for (int i = 0; i < got_order.size() && i < 4; i++)
      check($sformatf("tie_order%0d", i), got_order[i], exp_order[i]);

    // zero register discard
    do_reset();
    bus.eu0_valid = 1'b1; bus.eu0_rn = 6'd0; bus.eu0_data = 64'hFF;
    @(negedge clk);
    bus.eu0_rn = 6'd2; bus.eu0_data = 64'h22;
    @(negedge clk);
    idle_inputs();
    check("zero_we", bus.rf_we, 0);
    check("zero_free0", bus.free0_rn, 0);
    check("zero_rn", bus.rf_rn, 0);
    @(negedge clk);
    check("zero_next_we", bus.rf_we, 1);
    check("zero_next_rn", bus.rf_rn, 2);
    check("zero_next_data", bus.rf_data, 64'h22);
    check("zero_next_free0", bus.free0_rn, 2);

    // backpressure on unit 1 with unit 0 busy
    do_reset();
    acc = 0; dropped = 1'b0;
    bus.eu0_valid = 1'b1; bus.eu1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.eu0_rn = 6'(1 + (i % 30)); bus.eu0_data = 64'(i);
      bus.eu1_rn = 6'(40 + (i % 20)); bus.eu1_data = 64'(i + 100);
      if (!bus.eu1_ready) begin
        dropped = 1'b1;
        break;
      end
      acc++;
      @(negedge clk);
    end
    idle_inputs();
    check("bp_dropped", dropped, 1);
`ifdef WB_RR_EN
    check("bp_accepted", acc, 6);
`else
    check("bp_accepted", acc, 4);
`endif
    prev_ready = bus.eu1_ready;
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin
      @(negedge clk);
      if (bus.rf_we && bus.rf_rn >= 6'd40) begin
        found = 1'b1;
        check("bp_prev_ready", prev_ready, 0);
        check("bp_rise", bus.eu1_ready, 1);
      end else begin
        prev_ready = bus.eu1_ready;
      end
    end
    check("bp_found", found, 1);

    // asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.eu0_valid = 1'b1; bus.eu0_rn = 6'(1 + i);  bus.eu0_data = 64'(i);
      bus.eu1_valid = 1'b1; bus.eu1_rn = 6'(20 + i); bus.eu1_data = 64'(i);
      @(negedge clk);
    end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("mrst_we", bus.rf_we, 0);
    check("mrst_free0", bus.free0_rn, 0);
    check("mrst_rdy0", bus.eu0_ready, 1);
    check("mrst_rdy1", bus.eu1_ready, 1);
    check("mrst_idle", bus.idle, 1);
    @(negedge clk);
    rst = 1'b0;
    writes = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rf_we) writes++;
    end
    check("mrst_no_writes", writes, 0);

    // pointer wrap-around through unit 0
    do_reset();
    n = 0; w = 0;
    for (int c = 0; c < 60 && w < 12; c++) begin
      if (n < 12) begin
        bus.eu0_valid = 1'b1; bus.eu0_rn = 6'(n + 1); bus.eu0_data = 64'hA000 + 64'(n + 1);
      end else begin
        bus.eu0_valid = 1'b0;
      end
      take = bus.eu0_valid && bus.eu0_ready;
      @(negedge clk);
      if (take) n++;
      if (bus.rf_we) begin
        check($sformatf("wrap_rn%0d", w), bus.rf_rn, 64'(w + 1));
        check($sformatf("wrap_data%0d", w), bus.rf_data, 64'hA000 + 64'(w + 1));
        w++;
      end
    end
    idle_inputs();
    check("wrap_count", w, 12);
    writes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rf_we) writes++;
    end
    check("wrap_no_extra", writes, 0);
    check("wrap_idle", bus.idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
